// File: rtl/ann_bram_pkg.sv
// ann_bram_pkg: shared defaults and FSM encoding for the weight BRAM reader.
package ann_bram_pkg;
   localparam int DW_DEF    = 16;
   localparam int AW_DEF    = 5;
   localparam int DEPTH_DEF = 28;
   localparam int LW        = 6;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;
endpackage

// File: rtl/weight_skid_fifo.sv
// weight_skid_fifo: 2-entry FIFO whose head register drives the stream outputs.
module weight_skid_fifo #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_valid,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_mem [2];
   logic         r_wr, r_rd;
   logic [1:0]   r_cnt;
   logic         w_pop;
   assign o_valid = r_cnt != 2'd0;
   assign o_count = r_cnt;
   assign o_dout  = r_mem[r_rd];
   assign w_pop   = i_pop & o_valid;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
      end
endmodule

// File: rtl/weight_bram_reader.sv
// weight_bram_reader: streams a burst of weight words from a BRAM with wrapping
// addresses and a 2-entry output FIFO under valid/ready flow control.
module weight_bram_reader
   import ann_bram_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic [AW-1:0] i_start_addr,
   input  logic [LW-1:0] i_len,
   output logic [AW-1:0] o_bram_addr,
   output logic          o_bram_en,
   output logic          o_bram_we,
   input  logic [DW-1:0] i_bram_do,
   output logic [DW-1:0] o_w_data,
   output logic          o_w_valid,
   input  logic          i_w_ready,
   output logic          o_w_last,
   output logic [LW-1:0] o_w_index,
   output logic          o_busy,
   output logic          o_done
);
   state_t        r_state, w_state_nxt;
   logic          r_bram_en;
   logic [AW-1:0] r_bram_addr;
   logic [LW-1:0] r_len, r_issued, r_tag_idx;
   logic          r_tag_last;
   logic [LW-1:0] w_eff_len;
   logic          w_issue, w_pop, w_room, w_start_ok;
   logic [1:0]    w_occ;
   logic [2:0]    w_fill;
   assign w_eff_len  = (i_len > LW'(DEPTH)) ? LW'(DEPTH) : i_len;
   assign w_pop      = o_w_valid & i_w_ready;
   assign w_start_ok = (r_state == S_IDLE) & i_start;
   // The read issuing now (r_bram_en) lands in the FIFO at the next edge, so it
   // counts against the two slots before the next issue is committed.
   assign w_fill     = {1'b0, w_occ} + {2'b0, r_bram_en} - {2'b0, w_pop};
   assign w_room     = w_fill < 3'd2;
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE:
            if (i_start) begin
               w_state_nxt = (w_eff_len == '0) ? S_FINISH : S_FETCH;
               w_issue     = w_eff_len != '0;
            end
         S_FETCH:
            if (r_bram_en && r_issued == r_len) w_state_nxt = S_DRAIN;
            else w_issue = (r_issued < r_len) && w_room;
         S_DRAIN:
            if (w_pop && o_w_last) w_state_nxt = S_FINISH;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else r_state <= w_state_nxt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_bram_en   <= 1'b0;
         r_bram_addr <= '0;
         r_len       <= '0;
         r_issued    <= '0;
         r_tag_idx   <= '0;
         r_tag_last  <= 1'b0;
      end else begin
         r_bram_en <= w_issue;
         if (w_start_ok) r_len <= w_eff_len;
         if (w_issue) begin
            r_bram_addr <= w_start_ok ? i_start_addr :
                           (r_bram_addr == AW'(DEPTH - 1)) ? '0 : r_bram_addr + 1'b1;
            r_tag_idx   <= w_start_ok ? '0 : r_issued;
            r_tag_last  <= w_start_ok ? (w_eff_len == LW'(1)) : (r_issued == r_len - 1'b1);
            r_issued    <= w_start_ok ? LW'(1) : r_issued + 1'b1;
         end
      end
   weight_skid_fifo #(.W(DW + LW + 1)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (r_bram_en),
      .i_din   ({r_tag_last, r_tag_idx, i_bram_do}),
      .i_pop   (w_pop),
      .o_dout  ({o_w_last, o_w_index, o_w_data}),
      .o_valid (o_w_valid),
      .o_count (w_occ)
   );
   assign o_bram_en   = r_bram_en;
   assign o_bram_addr = r_bram_addr;
   assign o_bram_we   = 1'b0;
   assign o_busy      = r_state != S_IDLE;
   assign o_done      = r_state == S_FINISH;
endmodule

// File: tb/tb_weight_bram_reader.sv
// tb_weight_bram_reader: scoreboard bench with a negedge-registered BRAM model,
// randomized bursts and ready patterns, reset and re-START cases.
module tb_weight_bram_reader;
   localparam int DW = 16, AW = 5, DEPTH = 28, LW = 6;
   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [LW-1:0] len = '0;
   logic [AW-1:0] bram_addr;
   logic          bram_en, bram_we;
   logic [DW-1:0] bram_do = '0, w_data;
   logic          w_valid, w_ready = 1'b1, w_last, busy, done;
   logic [LW-1:0] w_index;
   logic [DW-1:0] mem [DEPTH];
   typedef struct {logic [DW-1:0] d; int idx; bit last;} exp_t;
   exp_t exp_q[$];
   int   addr_q[$];
   int   checks = 0, errors = 0, cyc = 0, ready_mode = 0;
   int   xfer_cnt = 0, en_cnt = 0, valid_cnt = 0, done_cnt = 0;
   int   first_valid_cyc = -1, last_xfer_cyc = -1, done_cyc = -1;

   weight_bram_reader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_start_addr(start_addr),
      .i_len(len), .o_bram_addr(bram_addr), .o_bram_en(bram_en), .o_bram_we(bram_we),
      .i_bram_do(bram_do), .o_w_data(w_data), .o_w_valid(w_valid), .i_w_ready(w_ready),
      .o_w_last(w_last), .o_w_index(w_index), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bram_en) bram_do <= mem[bram_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops the scoreboard on every transfer and read issue.
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   exp_t          e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bram_en) begin
            en_cnt++;
            check("bram_we", {63'b0, bram_we}, 64'd0);
            if (addr_q.size() == 0) fail_now("unexpected_read");
            else check("bram_addr", {59'b0, bram_addr}, 64'(addr_q.pop_front()));
         end
         if (w_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (prev_stall) begin
            check("stall_valid", {63'b0, w_valid}, 64'd1);
            check("stall_data", {48'b0, w_data}, {48'b0, prev_data});
         end
         if (w_valid && w_ready) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) fail_now("unexpected_word");
            else begin
               e = exp_q.pop_front();
               check("w_data", {48'b0, w_data}, {48'b0, e.d});
               check("w_index", {58'b0, w_index}, 64'(e.idx));
               check("w_last", {63'b0, w_last}, {63'b0, e.last});
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = w_valid && !w_ready;
         prev_data  = w_data;
      end else prev_stall = 1'b0;
   end

   // Ready patterns: 0 always high, 1 repeating 1,0,0, 2 random.
   initial begin
      int t = 0;
      forever begin
         @(posedge clk);
         #1;
         w_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (t % 3 == 0) : 1'($urandom % 2);
         t++;
      end
   end

   task automatic clear_stats();
      xfer_cnt = 0; en_cnt = 0; valid_cnt = 0; done_cnt = 0;
      first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
   endtask

   task automatic expect_burst(input int addr, input int l, output int eff);
      exp_t x;
      eff = (l > DEPTH) ? DEPTH : l;
      for (int k = 0; k < eff; k++) begin
         x.d    = DW'(16'h100 + (addr + k) % DEPTH);
         x.idx  = k;
         x.last = (k == eff - 1);
         exp_q.push_back(x);
         addr_q.push_back((addr + k) % DEPTH);
      end
   endtask

   task automatic issue_start(input int addr, input int l, output int c);
      @(posedge clk);
      #1;
      start = 1'b1; start_addr = AW'(addr); len = LW'(l); c = cyc;
      @(posedge clk);
      #1;
      start = 1'b0; start_addr = AW'($urandom); len = LW'($urandom);
   endtask

   task automatic run_burst(input int addr, input int l, input int mode, input int inject);
      int eff, c, n;
      ready_mode = mode;
      clear_stats();
      expect_burst(addr, l, eff);
      issue_start(addr, l, c);
      check("busy_after_start", {63'b0, busy}, 64'd1);
      n = 0;
      while (done_cnt == 0 && n < 400) begin
         @(negedge clk);
         n++;
         if (inject != 0 && n == inject) begin
            start = 1'b1; start_addr = AW'(3); len = LW'(5);
         end else start = 1'b0;
      end
      start = 1'b0;
      if (done_cnt == 0) fail_now("done_timeout");
      @(negedge clk);
      check("words", 64'(xfer_cnt), 64'(eff));
      check("reads", 64'(en_cnt), 64'(eff));
      check("done_count", 64'(done_cnt), 64'd1);
      check("queue_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
      check("busy_idle", {63'b0, busy}, 64'd0);
      if (eff > 0) begin
         check("done_after_last", 64'(done_cyc), 64'(last_xfer_cyc + 1));
         if (mode == 0) begin
            check("first_valid_lat", 64'(first_valid_cyc), 64'(c + 2));
            check("throughput", 64'(last_xfer_cyc - first_valid_cyc), 64'(eff - 1));
         end
      end else begin
         check("no_valid", 64'(valid_cnt), 64'd0);
         check("zero_len_done_lat", {63'b0, (done_cyc - c) <= 2}, 64'd1);
      end
      exp_q.delete();
      addr_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_en"}, {63'b0, bram_en}, 64'd0);
      check({tag, "_addr"}, {59'b0, bram_addr}, 64'd0);
      check({tag, "_valid"}, {63'b0, w_valid}, 64'd0);
      check({tag, "_last"}, {63'b0, w_last}, 64'd0);
      check({tag, "_index"}, {58'b0, w_index}, 64'd0);
      check({tag, "_data"}, {48'b0, w_data}, 64'd0);
      check({tag, "_busy"}, {63'b0, busy}, 64'd0);
      check({tag, "_done"}, {63'b0, done}, 64'd0);
   endtask

   initial begin
      int eff, c, n;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(16'h100 + i);
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
      run_burst(0, 28, 0, 0);
      run_burst(26, 4, 0, 0);
      run_burst(0, 10, 1, 0);
      run_burst(7, 0, 0, 0);
      run_burst(3, 40, 0, 0);
      // Reset in the middle of a burst, then a fresh short burst.
      ready_mode = 0;
      clear_stats();
      expect_burst(4, 8, eff);
      issue_start(4, 8, c);
      n = 0;
      while (xfer_cnt < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (xfer_cnt < 3) fail_now("mid_burst_timeout");
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      exp_q.delete();
      addr_q.delete();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      clear_stats();
      repeat (6) @(negedge clk);
      check("post_reset_words", 64'(valid_cnt), 64'd0);
      check("post_reset_reads", 64'(en_cnt), 64'd0);
      check("post_reset_done", 64'(done_cnt), 64'd0);
      run_burst(9, 2, 0, 0);
      run_burst(5, 10, 0, 4);
      run_burst(20, 12, 2, 3);
      for (int r = 0; r < 6; r++)
         run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 2)), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
